bcd_serial_adder_ctrl: RTL

BCD_SERIAL_ADDER_CTRL -- requirements
Module: bcd_serial_adder_ctrl

---
 rtl/bcd_serial_adder_ctrl.sv | 112 +++++++++++
 1 files changed

// File: rtl/bcd_serial_adder_ctrl.sv
// Digit-serial BCD adder: latches two NDIG-digit operands on start, adds one digit per
// cycle from digit 0 upward, then pulses done with S/cout/err held until the next start.
module bcd_serial_adder_ctrl #(
   parameter int unsigned NDIG = 4
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              start,
   input  logic [4*NDIG-1:0] A,
   input  logic [4*NDIG-1:0] B,
   input  logic              cin,
   output logic              busy,
   output logic              done,
   output logic [4*NDIG-1:0] S,
   output logic              cout,
   output logic              err
);

   localparam int unsigned IW = (NDIG > 1) ? $clog2(NDIG) : 1;

   typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

   state_e            state_q, state_d;
   logic [4*NDIG-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic              carry_q, carry_d;
   logic              cout_q, cout_d;
   logic              err_q, err_d;

   logic [3:0] a_dig, b_dig, sum_dig;
   logic [4:0] t;
   logic       dig_carry;

   // Per-digit BCD rule; (t+6) mod 16 equals t[3:0]+6 in 4 bits for any t < 32.
   always_comb begin
      a_dig = a_q[{idx_q, 2'b00} +: 4];
      b_dig = b_q[{idx_q, 2'b00} +: 4];
      t     = 5'(a_dig) + 5'(b_dig) + 5'(carry_q);
      if (t > 5'd9) begin
         sum_dig   = t[3:0] + 4'd6;
         dig_carry = 1'b1;
      end else begin
         sum_dig   = t[3:0];
         dig_carry = 1'b0;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      s_d     = s_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      err_d   = err_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               a_d     = A;
               b_d     = B;
               carry_d = cin;
               idx_d   = '0;
               err_d   = 1'b0;
               state_d = StAdd;
            end
         end
         StAdd: begin
            s_d[{idx_q, 2'b00} +: 4] = sum_dig;
            carry_d = dig_carry;
            err_d   = err_q | (a_dig > 4'd9) | (b_dig > 4'd9);
            if (idx_q == IW'(NDIG - 1)) begin
               cout_d  = dig_carry;
               state_d = StDone;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         s_q     <= s_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         err_q   <= err_d;
      end
   end

   assign busy = (state_q != StIdle);
   assign done = (state_q == StDone);
   assign S    = s_q;
   assign cout = cout_q;
   assign err  = err_q;

endmodule
